// File: rtl/mtl1_pkg.sv
// Shared MTL1 definitions: flash-arbiter state codes, the SPI bus bundle with
// its forced-idle value, and small elaboration-time helpers.
package mtl1_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_CPU_OWN   = 3'd0;
    localparam arb_state_t ST_DRAIN     = 3'd1;
    localparam arb_state_t ST_HALTING   = 3'd2;
    localparam arb_state_t ST_GUARD_IN  = 3'd3;
    localparam arb_state_t ST_FT_OWN    = 3'd4;
    localparam arb_state_t ST_GUARD_OUT = 3'd5;
    localparam arb_state_t ST_RESETTING = 3'd6;
    localparam arb_state_t ST_ABORT     = 3'd7;

    typedef enum logic [1:0] {
        OWN_CTRL,
        OWN_WR,
        OWN_IDLE
    } spi_owner_t;

    typedef struct packed {
        logic clk;
        logic mosi;
        logic cs;
    } spi_bus_t;

    localparam spi_bus_t SPI_IDLE = '{clk: 1'b0, mosi: 1'b0, cs: 1'b1};

    function automatic spi_owner_t owner_of(arb_state_t st);
        case (st)
            ST_CPU_OWN, ST_DRAIN: owner_of = OWN_CTRL;
            ST_FT_OWN:            owner_of = OWN_WR;
            default:              owner_of = OWN_IDLE;
        endcase
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A state lasting n cycles loads n-1 on entry and leaves when the count is 0.
    function automatic int unsigned load_of(int n);
        return (n > 0) ? int'(n - 1) : 0;
    endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// SPI and CPU-control bundle between the arbiter, the two flash masters,
// the flash pins and the 6809 HALT/RESET pins.
interface spi_flash_arbiter_if;

    logic i_ctrl_clk;
    logic i_ctrl_mosi;
    logic i_ctrl_cs;
    logic i_wr_clk;
    logic i_wr_mosi;
    logic i_wr_cs;
    logic o_SPI_CLK;
    logic o_SPI_MOSI;
    logic o_SPI_CS;
    logic o_cpu_grant;
    logic o_ft_grant;
    logic o_HALT;
    logic o_RESET;
    logic o_busy;

    modport master (
        output i_ctrl_clk, i_ctrl_mosi, i_ctrl_cs,
        output i_wr_clk, i_wr_mosi, i_wr_cs,
        input  o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
        input  o_cpu_grant, o_ft_grant, o_HALT, o_RESET, o_busy
    );

    modport slave (
        input  i_ctrl_clk, i_ctrl_mosi, i_ctrl_cs,
        input  i_wr_clk, i_wr_mosi, i_wr_cs,
        output o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
        output o_cpu_grant, o_ft_grant, o_HALT, o_RESET, o_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer for a single asynchronous bit; shared by the flash
// arbiter request line and the UART RX path.
module sync_2ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= (ff << 1) | STAGES'(d);
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Hands the shared SPI flash between the 6809 read path and the FT2232
// programmer, halting and resetting the CPU around each programming session.
module spi_flash_arbiter
    import mtl1_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HALT_SETTLE = 32,
    parameter int GUARD       = 4,
    parameter int RESET_HOLD  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_FT_CS,
    spi_flash_arbiter_if.slave   bus
);

    localparam int MAX_T = max3(HALT_SETTLE, GUARD, RESET_HOLD);
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] LOAD_SETTLE = CNT_W'(load_of(HALT_SETTLE));
    localparam logic [CNT_W-1:0] LOAD_GUARD  = CNT_W'(load_of(GUARD));
    localparam logic [CNT_W-1:0] LOAD_HOLD   = CNT_W'(load_of(RESET_HOLD));

    logic ft_sync;
    logic ft_req;

    arb_state_t       state, state_nx;
    spi_owner_t       owner;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             cnt_zero;
    logic             halt_n, halt_n_nx;
    logic             cpu_reset_n, cpu_reset_n_nx;
    logic             cs_seen, cs_seen_nx;
    logic             pending, pending_nx;

    spi_bus_t ctrl_bus, wr_bus, pin_bus;

    sync_2ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_ft_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_FT_CS),
        .q     (ft_sync)
    );

    assign ft_req   = ~ft_sync;
    assign cnt_zero = (cnt == '0);

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt_zero ? cnt : cnt - CNT_W'(1);
        halt_n_nx      = halt_n;
        cpu_reset_n_nx = cpu_reset_n;
        cs_seen_nx     = cs_seen;
        pending_nx     = pending;

        case (state)
            ST_CPU_OWN: begin
                if (ft_req || pending) begin
                    state_nx   = ST_DRAIN;
                    pending_nx = 1'b0;
                    cs_seen_nx = 1'b0;
                end
            end

            // A read frame is over only once ctrl CS is high on two samples in a row.
            ST_DRAIN: begin
                if (!ft_req) begin
                    state_nx = ST_CPU_OWN;
                end else if (bus.i_ctrl_cs) begin
                    if (cs_seen) begin
                        state_nx  = ST_HALTING;
                        halt_n_nx = 1'b0;
                        cnt_nx    = LOAD_SETTLE;
                    end else begin
                        cs_seen_nx = 1'b1;
                    end
                end else begin
                    cs_seen_nx = 1'b0;
                end
            end

            ST_HALTING: begin
                if (!ft_req) begin
                    state_nx = ST_ABORT;
                    cnt_nx   = LOAD_GUARD;
                end else if (cnt_zero) begin
                    state_nx = ST_GUARD_IN;
                    cnt_nx   = LOAD_GUARD;
                end
            end

            ST_GUARD_IN: begin
                if (cnt_zero) begin
                    state_nx = ST_FT_OWN;
                end
            end

            ST_FT_OWN: begin
                if (!ft_req) begin
                    state_nx = ST_GUARD_OUT;
                    cnt_nx   = LOAD_GUARD;
                end
            end

            ST_GUARD_OUT: begin
                if (ft_req) begin
                    pending_nx = 1'b1;
                end
                if (cnt_zero) begin
                    state_nx       = ST_RESETTING;
                    cpu_reset_n_nx = 1'b0;
                    cnt_nx         = LOAD_HOLD;
                end
            end

            // RESET is released one cycle ahead of HALT so the CPU leaves reset
            // while still halted, then runs from the fresh vectors.
            ST_RESETTING: begin
                if (ft_req) begin
                    pending_nx = 1'b1;
                end
                if (cnt_zero) begin
                    if (!cpu_reset_n) begin
                        cpu_reset_n_nx = 1'b1;
                    end else begin
                        halt_n_nx = 1'b1;
                        state_nx  = ST_CPU_OWN;
                    end
                end
            end

            ST_ABORT: begin
                if (ft_req) begin
                    pending_nx = 1'b1;
                end
                if (cnt_zero) begin
                    halt_n_nx = 1'b1;
                    state_nx  = ST_CPU_OWN;
                end
            end

            default: begin
                state_nx = ST_CPU_OWN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_CPU_OWN;
            owner       <= OWN_CTRL;
            cnt         <= '0;
            halt_n      <= 1'b1;
            cpu_reset_n <= 1'b1;
            cs_seen     <= 1'b0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_of(state_nx);
            cnt         <= cnt_nx;
            halt_n      <= halt_n_nx;
            cpu_reset_n <= cpu_reset_n_nx;
            cs_seen     <= cs_seen_nx;
            pending     <= pending_nx;
        end
    end

    // Pin mux is purely combinational from the registered owner, so the active
    // master's clock and data reach the flash without an added flop.
    assign ctrl_bus = '{clk: bus.i_ctrl_clk, mosi: bus.i_ctrl_mosi, cs: bus.i_ctrl_cs};
    assign wr_bus   = '{clk: bus.i_wr_clk,   mosi: bus.i_wr_mosi,   cs: bus.i_wr_cs};

    always_comb begin
        pin_bus = SPI_IDLE;
        case (owner)
            OWN_CTRL: pin_bus = ctrl_bus;
            OWN_WR:   pin_bus = wr_bus;
            default:  pin_bus = SPI_IDLE;
        endcase
    end

    assign bus.o_SPI_CLK   = pin_bus.clk;
    assign bus.o_SPI_MOSI  = pin_bus.mosi;
    assign bus.o_SPI_CS    = pin_bus.cs;
    assign bus.o_cpu_grant = (state == ST_CPU_OWN);
    assign bus.o_ft_grant  = (state == ST_FT_OWN);
    assign bus.o_busy      = (state != ST_CPU_OWN);
    assign bus.o_HALT      = halt_n;
    assign bus.o_RESET     = cpu_reset_n;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: every cycle the outputs are compared
// against an expected-output timeline built from the handover latency rules.
`timescale 1ns/1ps
module tb_spi_flash_arbiter;

    localparam int SS = 2;
    localparam int HS = 32;
    localparam int GD = 4;
    localparam int RH = 1024;

    localparam int OW_CTRL = 0;
    localparam int OW_WR   = 1;
    localparam int OW_IDLE = 2;

    typedef struct {
        int   start;
        logic cpu;
        logic ft;
        logic halt;
        logic rst;
        int   owner;
    } seg_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ft_cs = 1'b1;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    logic ctrl_run = 1'b0;
    logic wr_run   = 1'b0;
    logic rand_cs  = 1'b0;
    logic count_en = 1'b0;

    seg_t segs[$];

    int halt_fall = -1, halt_rise = -1, ft_rise = -1, ft_fall = -1;
    int rst_fall  = -1, rst_rise  = -1, busy_rise = -1;
    int rst_falls = 0,  clk_rises = 0;
    logic p_halt = 1'b1, p_rst = 1'b1, p_ft = 1'b0, p_busy = 1'b0, p_clk = 1'b0;

    spi_flash_arbiter_if bus ();

    spi_flash_arbiter #(
        .SYNC_STAGES (SS),
        .HALT_SETTLE (HS),
        .GUARD       (GD),
        .RESET_HOLD  (RH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_FT_CS (ft_cs),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(int start, logic cpu, logic ft, logic halt, logic rst, int owner);
        seg_t s;
        s.start = start;
        s.cpu   = cpu;
        s.ft    = ft;
        s.halt  = halt;
        s.rst   = rst;
        s.owner = owner;
        segs.push_back(s);
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ctrl_run) begin
                bus.i_ctrl_clk  = ~bus.i_ctrl_clk;
                bus.i_ctrl_mosi = 1'($urandom);
            end
            if (rand_cs) bus.i_ctrl_cs = 1'($urandom);
            if (wr_run) begin
                bus.i_wr_clk  = ~bus.i_wr_clk;
                bus.i_wr_mosi = 1'($urandom);
            end
        end
    endtask

    // Compare process: the latest timeline segment starting at or before this
    // cycle gives the expected grants, CPU pins and which master owns the pins.
    always @(negedge clk) begin
        seg_t       e;
        logic [2:0] pins;
        logic [7:0] exp_v;
        logic [7:0] act_v;
        if (segs.size() > 0) begin
            e = segs[0];
            foreach (segs[i]) if (segs[i].start <= cyc) e = segs[i];
            case (e.owner)
                OW_CTRL: pins = {bus.i_ctrl_cs, bus.i_ctrl_clk, bus.i_ctrl_mosi};
                OW_WR:   pins = {bus.i_wr_cs, bus.i_wr_clk, bus.i_wr_mosi};
                default: pins = 3'b100;
            endcase
            exp_v = {e.cpu, e.ft, e.halt, e.rst, ~e.cpu, pins};
            act_v = {bus.o_cpu_grant, bus.o_ft_grant, bus.o_HALT, bus.o_RESET, bus.o_busy,
                     bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI};
            check($sformatf("outputs@cyc%0d", cyc), 32'(act_v), 32'(exp_v));
        end
    end

    // Edge timestamps used by the literal latency checks.
    always @(negedge clk) begin
        if (p_halt && !bus.o_HALT) halt_fall = cyc;
        if (!p_halt && bus.o_HALT) halt_rise = cyc;
        if (!p_ft && bus.o_ft_grant) ft_rise = cyc;
        if (p_ft && !bus.o_ft_grant) ft_fall = cyc;
        if (p_rst && !bus.o_RESET) begin
            rst_fall = cyc;
            rst_falls++;
        end
        if (!p_rst && bus.o_RESET) rst_rise = cyc;
        if (!p_busy && bus.o_busy) busy_rise = cyc;
        if (count_en && !p_clk && bus.o_SPI_CLK) clk_rises++;
        p_halt = bus.o_HALT;
        p_rst  = bus.o_RESET;
        p_ft   = bus.o_ft_grant;
        p_busy = bus.o_busy;
        p_clk  = bus.o_SPI_CLK;
    end

    initial begin
        int t_a, t_b, t_c, t_h, t_r, falls0;

        bus.i_ctrl_clk  = 1'b0;
        bus.i_ctrl_mosi = 1'b0;
        bus.i_ctrl_cs   = 1'b1;
        bus.i_wr_clk    = 1'b0;
        bus.i_wr_mosi   = 1'b0;
        bus.i_wr_cs     = 1'b1;
        push(0, 1'b1, 1'b0, 1'b1, 1'b1, OW_CTRL);

        #1 reset = 1'b0;
        step(3);
        check("rst_cpu_grant", 32'(bus.o_cpu_grant), 1);
        check("rst_ft_grant",  32'(bus.o_ft_grant), 0);
        check("rst_busy",      32'(bus.o_busy), 0);
        check("rst_halt",      32'(bus.o_HALT), 1);
        check("rst_reset",     32'(bus.o_RESET), 1);
        check("rst_spi_cs",    32'(bus.o_SPI_CS), 1);
        reset = 1'b1;

        // Idle: the read path owns the pins and may toggle freely.
        ctrl_run    = 1'b1;
        rand_cs     = 1'b1;
        wr_run      = 1'b1;
        bus.i_wr_cs = 1'b0;
        step(20);
        rand_cs = 1'b0;

        // Drain: request arrives mid read frame, frame ends 40 cycles later.
        bus.i_ctrl_cs = 1'b0;
        step(1);
        t_a   = cyc;
        ft_cs = 1'b0;
        push(t_a + SS + 1, 1'b0, 1'b0, 1'b1, 1'b1, OW_CTRL);
        step(40);
        t_b = cyc;
        bus.i_ctrl_cs = 1'b1;
        t_h = ((t_b > t_a + SS + 1) ? t_b : t_a + SS + 1) + 2;
        push(t_h, 1'b0, 1'b0, 1'b0, 1'b1, OW_IDLE);
        push(t_h + HS + GD, 1'b0, 1'b1, 1'b0, 1'b1, OW_WR);
        step(t_h + HS + GD + 2 - cyc);
        check("drain_entry_latency", 32'(busy_rise - t_a), 3);
        check("halt_after_cs_rise",  32'(halt_fall - t_b), 2);
        check("halt_to_ft_grant",    32'(ft_rise - halt_fall), 36);

        // Programming: 100 writer SPI clocks, then release and CPU reset.
        wr_run       = 1'b0;
        bus.i_wr_clk = 1'b0;
        step(1);
        count_en = 1'b1;
        wr_run   = 1'b1;
        step(200);
        count_en = 1'b0;
        check("wr_clocks_on_pins", 32'(clk_rises), 100);

        t_c   = cyc;
        ft_cs = 1'b1;
        t_r   = t_c + SS + 1 + GD;
        push(t_c + SS + 1, 1'b0, 1'b0, 1'b0, 1'b1, OW_IDLE);
        push(t_r,          1'b0, 1'b0, 1'b0, 1'b0, OW_IDLE);
        push(t_r + RH,     1'b0, 1'b0, 1'b0, 1'b1, OW_IDLE);
        push(t_r + RH + 1, 1'b1, 1'b0, 1'b1, 1'b1, OW_CTRL);

        // Re-request pulse during the reset hold is deferred until CPU_OWN.
        step(100);
        ft_cs = 1'b0;
        step(20);
        ft_cs = 1'b1;
        push(t_r + RH + 2, 1'b0, 1'b0, 1'b1, 1'b1, OW_CTRL);
        push(t_r + RH + 3, 1'b1, 1'b0, 1'b1, 1'b1, OW_CTRL);
        step(t_r + RH + 10 - cyc);
        check("guard_out_length",    32'(rst_fall - ft_fall), 4);
        check("reset_hold_length",   32'(rst_rise - rst_fall), 1024);
        check("halt_after_reset",    32'(halt_rise - rst_rise), 1);
        check("rerequest_drain",     32'(busy_rise - halt_rise), 1);
        check("cpu_grant_after_prog", 32'(bus.o_cpu_grant), 1);

        // Abort: request withdrawn at cycle 10 of HALTING.
        falls0 = rst_falls;
        t_a    = cyc;
        ft_cs  = 1'b0;
        push(t_a + SS + 1, 1'b0, 1'b0, 1'b1, 1'b1, OW_CTRL);
        t_h = t_a + SS + 3;
        push(t_h, 1'b0, 1'b0, 1'b0, 1'b1, OW_IDLE);
        step(t_h + 9 - cyc);
        t_c   = cyc;
        ft_cs = 1'b1;
        push(t_c + SS + 1 + GD, 1'b1, 1'b0, 1'b1, 1'b1, OW_CTRL);
        step(20);
        check("abort_halt_release", 32'(halt_rise - t_c), 7);
        check("abort_no_reset",     32'(rst_falls), 32'(falls0));

        // Asynchronous reset while the programmer owns the flash.
        t_a   = cyc;
        ft_cs = 1'b0;
        push(t_a + SS + 1, 1'b0, 1'b0, 1'b1, 1'b1, OW_CTRL);
        t_h = t_a + SS + 3;
        push(t_h, 1'b0, 1'b0, 1'b0, 1'b1, OW_IDLE);
        push(t_h + HS + GD, 1'b0, 1'b1, 1'b0, 1'b1, OW_WR);
        step(t_h + HS + GD + 5 - cyc);
        ctrl_run       = 1'b0;
        wr_run         = 1'b0;
        bus.i_ctrl_clk = 1'b0;
        bus.i_wr_clk   = 1'b1;
        bus.i_wr_cs    = 1'b0;
        #2;
        reset = 1'b0;
        push(cyc, 1'b1, 1'b0, 1'b1, 1'b1, OW_CTRL);
        #1;
        check("async_cpu_grant", 32'(bus.o_cpu_grant), 1);
        check("async_ft_grant",  32'(bus.o_ft_grant), 0);
        check("async_busy",      32'(bus.o_busy), 0);
        check("async_halt",      32'(bus.o_HALT), 1);
        check("async_reset",     32'(bus.o_RESET), 1);
        check("async_spi_cs",    32'(bus.o_SPI_CS), 1);
        check("async_spi_clk",   32'(bus.o_SPI_CLK), 0);
        ft_cs = 1'b1;
        step(3);
        reset = 1'b1;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
